// File: rtl/pdu_ring_buffer_mc.sv
// Multi-channel PDU ring buffer: NUM_CH rings statically partitioned in one BRAM, round-robin DMA descriptor issue.
// Optional overflow guard enabled by defining RB_OVF_CHECK_EN.
module pdu_ring_buffer_mc #(
    parameter int NUM_CH    = 4,
    parameter int CH_DEPTH  = 512,
    parameter int DWIDTH    = 514,
    parameter int THRESHOLD = 64,
    parameter int AF_LEVEL  = 128,
    parameter int AW        = $clog2(CH_DEPTH),
    parameter int CW        = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [CW-1:0]        wr_ch,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DWIDTH-1:0]    wr_data,
    input  logic                 update_valid,
    input  logic [CW-1:0]        update_ch,
    input  logic [AW-1:0]        update_size,
    output logic [NUM_CH*AW-1:0] wr_base_addr,
    output logic [NUM_CH-1:0]    almost_full,
    output logic [NUM_CH-1:0]    ovf_err,
    input  logic                 rd_en,
    input  logic [CW-1:0]        rd_ch,
    input  logic [AW-1:0]        rd_addr,
    output logic                 rd_valid,
    output logic [DWIDTH-3:0]    rd_data,
    output logic                 rd_eop,
    output logic                 dma_start,
    output logic [CW-1:0]        dma_ch,
    output logic [CW+AW-1:0]     dma_base_addr,
    output logic [AW-1:0]        dma_size,
    input  logic                 dma_done
);

    localparam logic [AW:0] MAX_SLOT = (AW+1)'(CH_DEPTH - THRESHOLD);
    localparam logic [AW:0] DEPTH_W  = (AW+1)'(CH_DEPTH);
    localparam logic [AW:0] AF_W     = (AW+1)'(AF_LEVEL);

    typedef enum logic {IDLE, WAIT} state_t;

    logic [DWIDTH-1:0] mem [NUM_CH*CH_DEPTH];
    logic [DWIDTH-3:0] mem_q_data;
    logic              mem_q_eop;

    logic          r1_valid;
    logic [CW-1:0] r1_ch, r2_ch;
    logic [AW-1:0] r1_addr, r2_addr;
    logic [AW:0]   head_next;

    logic [AW-1:0] head      [NUM_CH];
    logic [AW-1:0] tail      [NUM_CH];
    logic [AW:0]   last_tail [NUM_CH];
    logic [AW:0]   occ       [NUM_CH];
    logic [AW:0]   free      [NUM_CH];
    logic [AW-1:0] send      [NUM_CH];

    logic [AW:0]   commit_sum;
    logic          commit_ok;

    state_t        state, state_next;
    logic [CW-1:0] rr, grant, cand;
    logic          found;

    // Physical address is {channel, local}; read data is registered once here and once more at the output.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{wr_ch, wr_addr}] <= wr_data;
        if (rd_en) begin
            mem_q_data <= mem[{rd_ch, rd_addr}][DWIDTH-1:2];
            mem_q_eop  <= mem[{rd_ch, rd_addr}][0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_ch    <= '0;
            r1_addr  <= '0;
            r2_ch    <= '0;
            r2_addr  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_eop   <= 1'b0;
        end else begin
            r1_valid <= rd_en;
            r1_ch    <= rd_ch;
            r1_addr  <= rd_addr;
            r2_ch    <= r1_ch;
            r2_addr  <= r1_addr;
            rd_valid <= r1_valid;
            rd_data  <= mem_q_data;
            rd_eop   <= mem_q_eop;
        end
    end

    // A wrapped ring holds [head, last_tail) plus [0, tail); DMA only sends the contiguous upper part.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (tail[i] < head[i]) begin
                occ[i]  = last_tail[i] - {1'b0, head[i]} + {1'b0, tail[i]};
                send[i] = last_tail[i][AW-1:0] - head[i];
            end else begin
                occ[i]  = {1'b0, tail[i]} - {1'b0, head[i]};
                send[i] = tail[i] - head[i];
            end
            free[i] = DEPTH_W - occ[i] - (AW+1)'(1);
            wr_base_addr[i*AW +: AW] = tail[i];
        end
    end

    assign commit_sum = {1'b0, tail[update_ch]} + {1'b0, update_size};
    assign head_next  = {1'b0, r2_addr} + (AW+1)'(1);

`ifdef RB_OVF_CHECK_EN
    logic ovf_hit;
    assign ovf_hit   = update_valid && ({1'b0, update_size} > free[update_ch]);
    assign commit_ok = update_valid && !ovf_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_err <= '0;
        else if (ovf_hit)
            ovf_err[update_ch] <= 1'b1;
    end
`else
    assign commit_ok = update_valid;
    assign ovf_err   = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                head[i]      <= '0;
                tail[i]      <= '0;
                last_tail[i] <= '0;
            end
            almost_full <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                almost_full[i] <= (free[i] < AF_W);
            if (commit_ok) begin
                if (commit_sum < MAX_SLOT) begin
                    tail[update_ch] <= commit_sum[AW-1:0];
                end else begin
                    last_tail[update_ch] <= commit_sum;
                    tail[update_ch]      <= '0;
                end
            end
            if (rd_valid && rd_eop)
                head[r2_ch] <= (head_next >= MAX_SLOT) ? '0 : head_next[AW-1:0];
        end
    end

    // Scan starts just after the last granted channel so every ring gets a turn.
    always_comb begin
        state_next = state;
        found      = 1'b0;
        grant      = '0;
        cand       = '0;
        case (state)
            IDLE: begin
                for (int i = 1; i <= NUM_CH; i++) begin
                    cand = rr + CW'(i);
                    if (!found && occ[cand] != '0) begin
                        found = 1'b1;
                        grant = cand;
                    end
                end
                if (found)
                    state_next = WAIT;
            end
            WAIT: begin
                if (dma_done)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr            <= '0;
            dma_start     <= 1'b0;
            dma_ch        <= '0;
            dma_base_addr <= '0;
            dma_size      <= '0;
        end else begin
            state     <= state_next;
            dma_start <= found;
            if (found) begin
                rr            <= grant;
                dma_ch        <= grant;
                dma_base_addr <= {grant, head[grant]};
                dma_size      <= send[grant];
            end
        end
    end

endmodule

// File: tb/tb_pdu_ring_buffer_mc.sv
// Randomized scoreboard bench for pdu_ring_buffer_mc; reference model tracks rings as plain integers.
module tb_pdu_ring_buffer_mc;

    localparam int NUM_CH    = 4;
    localparam int CH_DEPTH  = 512;
    localparam int DWIDTH    = 514;
    localparam int THRESHOLD = 64;
    localparam int AF_LEVEL  = 128;
    localparam int AW        = 9;
    localparam int CW        = 2;
    localparam int MAX_SLOT  = CH_DEPTH - THRESHOLD;
    localparam int NCYC      = 3000;
    localparam int RST_AT    = 1500;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 wr_en = 1'b0;
    logic [CW-1:0]        wr_ch = '0;
    logic [AW-1:0]        wr_addr = '0;
    logic [DWIDTH-1:0]    wr_data = '0;
    logic                 update_valid = 1'b0;
    logic [CW-1:0]        update_ch = '0;
    logic [AW-1:0]        update_size = '0;
    logic [NUM_CH*AW-1:0] wr_base_addr;
    logic [NUM_CH-1:0]    almost_full;
    logic [NUM_CH-1:0]    ovf_err;
    logic                 rd_en = 1'b0;
    logic [CW-1:0]        rd_ch = '0;
    logic [AW-1:0]        rd_addr = '0;
    logic                 rd_valid;
    logic [DWIDTH-3:0]    rd_data;
    logic                 rd_eop;
    logic                 dma_start;
    logic [CW-1:0]        dma_ch;
    logic [CW+AW-1:0]     dma_base_addr;
    logic [AW-1:0]        dma_size;
    logic                 dma_done = 1'b0;

    pdu_ring_buffer_mc dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data),
        .update_valid(update_valid), .update_ch(update_ch), .update_size(update_size),
        .wr_base_addr(wr_base_addr), .almost_full(almost_full), .ovf_err(ovf_err),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_eop(rd_eop),
        .dma_start(dma_start), .dma_ch(dma_ch), .dma_base_addr(dma_base_addr),
        .dma_size(dma_size), .dma_done(dma_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int edge_n; logic [DWIDTH-3:0] data; logic eop; } rd_exp_t;
    typedef struct { int edge_n; int ch; int base; int size; } dma_exp_t;
    typedef struct { int edge_n; logic [NUM_CH*AW-1:0] tails; logic [NUM_CH-1:0] af; logic [NUM_CH-1:0] ovf; } st_exp_t;

    rd_exp_t  rd_q[$];
    dma_exp_t dma_q[$];
    st_exp_t  st_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: ring pointers as integers, stored flits keyed by physical address.
    int m_head [NUM_CH];
    int m_tail [NUM_CH];
    int m_last [NUM_CH];
    logic [NUM_CH-1:0] m_af, m_ovf;
    int m_rr;
    bit m_wait;
    logic [DWIDTH-1:0] m_mem [int];
    int wlist[$];
    bit p1_v, p2_v, p1_eop, p2_eop;
    int p1_ch, p2_ch, p1_addr, p2_addr;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s @edge %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic checkData(input string name, input logic [DWIDTH-3:0] act, input logic [DWIDTH-3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s @edge %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_head[c] = 0;
            m_tail[c] = 0;
            m_last[c] = 0;
        end
        m_af = '0;
        m_ovf = '0;
        m_rr = 0;
        m_wait = 0;
        p1_v = 0;
        p2_v = 0;
        rd_q.delete();
        dma_q.delete();
    endtask

    task automatic pushStatus(input int e);
        st_exp_t s;
        s.edge_n = e;
        for (int c = 0; c < NUM_CH; c++)
            s.tails[c*AW +: AW] = AW'(m_tail[c]);
        s.af = m_af;
        s.ovf = m_ovf;
        st_q.push_back(s);
    endtask

    // Drives one cycle of inputs and advances the model to the state the next clock edge (number e) produces.
    task automatic applyStimulus(input int e, input bit quiet);
        int occ [NUM_CH];
        int fr  [NUM_CH];
        int snd [NUM_CH];
        logic [DWIDTH-1:0] wd, rv;
        int pa, wpa, us, uc, sum, c;
        bit drop, n_v, n_eop;
        rd_exp_t r;
        dma_exp_t d;

        for (int k = 0; k < NUM_CH; k++) begin
            if (m_tail[k] < m_head[k]) begin
                occ[k] = (m_last[k] - m_head[k] + m_tail[k]) & 1023;
                snd[k] = (m_last[k] - m_head[k]) & 511;
            end else begin
                occ[k] = (m_tail[k] - m_head[k]) & 1023;
                snd[k] = occ[k] & 511;
            end
            fr[k] = (CH_DEPTH - occ[k] - 1) & 1023;
        end

        rd_en = !quiet && wlist.size() > 0 && $urandom_range(0, 9) < 4;
        n_v = rd_en;
        n_eop = 0;
        pa = 0;
        if (rd_en) begin
            pa = wlist[$urandom_range(0, wlist.size() - 1)];
            rd_ch = CW'(pa / CH_DEPTH);
            rd_addr = AW'(pa % CH_DEPTH);
            rv = m_mem[pa];
            r.edge_n = e + 1;
            r.data = rv[DWIDTH-1:2];
            r.eop = rv[0];
            n_eop = rv[0];
            rd_q.push_back(r);
        end

        wr_en = !quiet && $urandom_range(0, 1) == 1;
        if (wr_en) begin
            wd = '0;
            for (int k = 0; k < 17; k++)
                wd = {wd[DWIDTH-33:0], $urandom()};
            wd[0] = ($urandom_range(0, 3) == 0);
            wr_data = wd;
            wr_ch = CW'($urandom_range(0, NUM_CH - 1));
            wr_addr = AW'($urandom_range(0, CH_DEPTH - 1));
            wpa = int'(wr_ch) * CH_DEPTH + int'(wr_addr);
            if (!m_mem.exists(wpa))
                wlist.push_back(wpa);
            m_mem[wpa] = wd;
        end

        update_valid = !quiet && $urandom_range(0, 3) == 0;
        uc = $urandom_range(0, NUM_CH - 1);
        us = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 511) : $urandom_range(1, 40);
        update_ch = CW'(uc);
        update_size = AW'(us);

        dma_done = $urandom_range(0, 3) == 0;

        if (!m_wait) begin
            for (int i = 1; i <= NUM_CH; i++) begin
                c = (m_rr + i) % NUM_CH;
                if (!m_wait && occ[c] != 0) begin
                    d.edge_n = e;
                    d.ch = c;
                    d.base = c * CH_DEPTH + m_head[c];
                    d.size = snd[c];
                    dma_q.push_back(d);
                    m_wait = 1;
                    m_rr = c;
                end
            end
        end else if (dma_done) begin
            m_wait = 0;
        end

        if (update_valid) begin
            sum = m_tail[uc] + us;
            drop = 0;
`ifdef RB_OVF_CHECK_EN
            if (us > fr[uc]) begin
                drop = 1;
                m_ovf[uc] = 1'b1;
            end
`endif
            if (!drop) begin
                if (sum < MAX_SLOT) begin
                    m_tail[uc] = sum;
                end else begin
                    m_last[uc] = sum;
                    m_tail[uc] = 0;
                end
            end
        end

        if (p2_v && p2_eop)
            m_head[p2_ch] = (p2_addr + 1 >= MAX_SLOT) ? 0 : p2_addr + 1;

        for (int k = 0; k < NUM_CH; k++)
            m_af[k] = fr[k] < AF_LEVEL;

        p2_v = p1_v;
        p2_eop = p1_eop;
        p2_ch = p1_ch;
        p2_addr = p1_addr;
        p1_v = n_v;
        p1_eop = n_eop;
        p1_ch = pa / CH_DEPTH;
        p1_addr = pa % CH_DEPTH;

        pushStatus(e);
    endtask

    // Monitor: pops expectations whenever the DUT presents a read result, descriptor or new status.
    initial begin
        rd_exp_t r;
        dma_exp_t d;
        st_exp_t s;
        forever begin
            @(posedge clk);
            #1;
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    checkOutput("rd_valid_spurious", 64'(rd_valid), 64'd0);
                end else begin
                    r = rd_q.pop_front();
                    checkOutput("rd_latency", 64'(cyc), 64'(r.edge_n));
                    checkData("rd_data", rd_data, r.data);
                    checkOutput("rd_eop", 64'(rd_eop), 64'(r.eop));
                end
            end
            while (rd_q.size() > 0 && rd_q[0].edge_n <= cyc) begin
                r = rd_q.pop_front();
                checkOutput("rd_valid_missing", 64'(rd_valid), 64'd1);
            end
            if (dma_start) begin
                if (dma_q.size() == 0) begin
                    checkOutput("dma_start_spurious", 64'(dma_start), 64'd0);
                end else begin
                    d = dma_q.pop_front();
                    checkOutput("dma_timing", 64'(cyc), 64'(d.edge_n));
                    checkOutput("dma_ch", 64'(dma_ch), 64'(d.ch));
                    checkOutput("dma_base_addr", 64'(dma_base_addr), 64'(d.base));
                    checkOutput("dma_size", 64'(dma_size), 64'(d.size));
                end
            end
            while (dma_q.size() > 0 && dma_q[0].edge_n <= cyc) begin
                d = dma_q.pop_front();
                checkOutput("dma_start_missing", 64'(dma_start), 64'd1);
            end
            if (st_q.size() > 0 && st_q[0].edge_n == cyc) begin
                s = st_q.pop_front();
                checkOutput("wr_base_addr", 64'(wr_base_addr), 64'(s.tails));
                checkOutput("almost_full", 64'(almost_full), 64'(s.af));
                checkOutput("ovf_err", 64'(ovf_err), 64'(s.ovf));
            end
        end
    end

    initial begin
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset_wr_base_addr", 64'(wr_base_addr), 64'd0);
        checkOutput("reset_almost_full", 64'(almost_full), 64'd0);
        checkOutput("reset_ovf_err", 64'(ovf_err), 64'd0);
        checkOutput("reset_rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("reset_dma_start", 64'(dma_start), 64'd0);
        checkOutput("reset_dma_fields", 64'({dma_ch, dma_base_addr, dma_size}), 64'd0);

        for (int n = 0; n < NCYC; n++) begin
            @(negedge clk);
            if (n == RST_AT || n == RST_AT + 1) begin
                rst = 1'b1;
                wr_en = 1'b0;
                rd_en = 1'b0;
                update_valid = 1'b0;
                dma_done = 1'b0;
                modelReset();
                pushStatus(cyc + 1);
            end else begin
                rst = 1'b0;
                applyStimulus(cyc + 1, 1'b0);
            end
        end
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            applyStimulus(cyc + 1, 1'b1);
        end
        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
